// File: rtl/fire_packet_tx.sv
// -----------------------------------------------------------------------------
// fire_packet_tx
//
// Transmit end of the MMCAM firing path. When the matching stage raises FIRE,
// the matched pair is stored in a small FIFO as {tag, left, right}. The two
// operands are placed left/right according to the L/R bit of the incoming
// token. Each stored packet is then sent downstream over a clocked four-phase
// REQ/ACK handshake.
//
// Ports
//   CP        in   clock, rising edge
//   MR        in   master reset, asynchronous, active-low
//   FIRE      in   match fired this cycle
//   TAG       in   color/gen/dest of the matched token
//   IN_LR     in   L/R bit of the incoming token (0 = left, 1 = right)
//   IN_DATA   in   incoming token operand
//   ENT_DATA  in   operand held by the matched entry
//   FULL      out  FIFO holds DEPTH packets (back-pressure to matching stage)
//   OVF       out  sticky: a FIRE was refused while FULL
//   REQ       out  packet valid to downstream
//   ACK       in   downstream acknowledge
//   PKT_TAG   out  packet tag
//   PKT_L     out  left operand
//   PKT_R     out  right operand
//
// Optional build macro FIRE_PKT_CNT_EN adds:
//   FIRE_CNT  out  16-bit count of completed handshakes (wraps)
//   DROP_CNT  out  8-bit count of refused FIREs (saturates)
// -----------------------------------------------------------------------------
module fire_packet_tx #(
    parameter int unsigned TAG_W  = 18,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              CP,
    input  logic              MR,
    input  logic              FIRE,
    input  logic [TAG_W-1:0]  TAG,
    input  logic              IN_LR,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [DATA_W-1:0] ENT_DATA,
    output logic              FULL,
    output logic              OVF,
    output logic              REQ,
    input  logic              ACK,
    output logic [TAG_W-1:0]  PKT_TAG,
    output logic [DATA_W-1:0] PKT_L,
    output logic [DATA_W-1:0] PKT_R
`ifdef FIRE_PKT_CNT_EN
    ,
    output logic [15:0]       FIRE_CNT,
    output logic [7:0]        DROP_CNT
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = TAG_W + 2 * DATA_W;
    localparam logic [CNT_W-1:0] FullCount = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReqHi,
        StReqLo
    } state_e;

    // -------------------------------------------------------------------------
    // Capture side
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] cap_l;
    logic [DATA_W-1:0] cap_r;
    logic [ENT_W-1:0]  cap_entry;
    logic              full;
    logic              push;
    logic              refuse;

    always_comb begin
        cap_l     = IN_LR ? ENT_DATA : IN_DATA;
        cap_r     = IN_LR ? IN_DATA  : ENT_DATA;
        cap_entry = {TAG, cap_l, cap_r};
    end

    // -------------------------------------------------------------------------
    // FIFO state
    // -------------------------------------------------------------------------
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ENT_W-1:0] head;

    // FSM strobes
    logic             load;
    logic             pop;

    // Full is decoded from the registered count, so a pop in the same cycle
    // cannot open a slot for a FIRE arriving while full.
    assign full   = (count_q == FullCount);
    assign push   = FIRE && !full;
    assign refuse = FIRE && full;
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | refuse;

        // DEPTH is a power of two, so natural pointer overflow gives mod DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; a slot is only read after it has been written.
    always_ff @(posedge CP) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cap_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    state_e state_q, state_d;
    logic   req_q, req_d;

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A high ACK left over from a previous transfer must drop
                // before a new REQ is raised.
                if ((count_q != '0) && !ACK) begin
                    state_d = StReqHi;
                end
            end
            StReqHi: begin
                if (ACK) begin
                    state_d = StReqLo;
                end
            end
            StReqLo: begin
                if (!ACK) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load  = (state_q == StIdle) && (count_q != '0) && !ACK;
        pop   = (state_q == StReqHi) && ACK;
        req_d = req_q;
        if (load) begin
            req_d = 1'b1;
        end else if (pop) begin
            req_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Packet output registers, held stable from REQ rise until the next load
    // -------------------------------------------------------------------------
    logic [TAG_W-1:0]  pkt_tag_q;
    logic [DATA_W-1:0] pkt_l_q;
    logic [DATA_W-1:0] pkt_r_q;

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            req_q     <= 1'b0;
            pkt_tag_q <= '0;
            pkt_l_q   <= '0;
            pkt_r_q   <= '0;
        end else begin
            req_q <= req_d;
            if (load) begin
                pkt_tag_q <= head[ENT_W-1 -: TAG_W];
                pkt_l_q   <= head[2*DATA_W-1 -: DATA_W];
                pkt_r_q   <= head[DATA_W-1:0];
            end
        end
    end

    assign FULL    = full;
    assign OVF     = ovf_q;
    assign REQ     = req_q;
    assign PKT_TAG = pkt_tag_q;
    assign PKT_L   = pkt_l_q;
    assign PKT_R   = pkt_r_q;

`ifdef FIRE_PKT_CNT_EN
    // -------------------------------------------------------------------------
    // Statistics counters
    // -------------------------------------------------------------------------
    logic [15:0] fire_cnt_q, fire_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    always_comb begin
        fire_cnt_d = fire_cnt_q;
        drop_cnt_d = drop_cnt_q;
        // A pop is exactly the REQ_HI -> REQ_LO transition.
        if (pop) begin
            fire_cnt_d = fire_cnt_q + 16'd1;
        end
        if (refuse && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            fire_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fire_cnt_q <= fire_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign FIRE_CNT = fire_cnt_q;
    assign DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fire_packet_tx.sv
module tb_fire_packet_tx;

    localparam int unsigned TAG_W  = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ENT_W  = TAG_W + 2 * DATA_W;

    logic              CP = 1'b0;
    logic              MR = 1'b0;
    logic              FIRE = 1'b0;
    logic [TAG_W-1:0]  TAG = '0;
    logic              IN_LR = 1'b0;
    logic [DATA_W-1:0] IN_DATA = '0;
    logic [DATA_W-1:0] ENT_DATA = '0;
    logic              FULL;
    logic              OVF;
    logic              REQ;
    logic              ACK;
    logic [TAG_W-1:0]  PKT_TAG;
    logic [DATA_W-1:0] PKT_L;
    logic [DATA_W-1:0] PKT_R;
`ifdef FIRE_PKT_CNT_EN
    logic [15:0]       FIRE_CNT;
    logic [7:0]        DROP_CNT;
`endif

    fire_packet_tx #(
        .TAG_W (TAG_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .CP      (CP),
        .MR      (MR),
        .FIRE    (FIRE),
        .TAG     (TAG),
        .IN_LR   (IN_LR),
        .IN_DATA (IN_DATA),
        .ENT_DATA(ENT_DATA),
        .FULL    (FULL),
        .OVF     (OVF),
        .REQ     (REQ),
        .ACK     (ACK),
        .PKT_TAG (PKT_TAG),
        .PKT_L   (PKT_L),
        .PKT_R   (PKT_R)
`ifdef FIRE_PKT_CNT_EN
        ,
        .FIRE_CNT(FIRE_CNT),
        .DROP_CNT(DROP_CNT)
`endif
    );

    always #5 CP = ~CP;

    int checks = 0;
    int errors = 0;

    // Expected packets, {tag, left, right}, in delivery order.
    logic [ENT_W-1:0] exp_q [$];

    // ACK source: automatic responder or manual drive from the stimulus.
    logic ack_en   = 1'b0;
    logic ack_man  = 1'b0;
    logic ack_auto = 1'b0;
    int   ack_dly  = 0;
    int   ack_wait = 0;
    assign ACK = ack_en ? ack_auto : ack_man;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset();
        MR = 1'b0;
        #2;
        MR = 1'b1;
        exp_q.delete();
    endtask

    // Queue the packet the DUT must produce for this capture and drive FIRE.
    task automatic fire_set(input logic [TAG_W-1:0] t, input logic lr,
                            input logic [DATA_W-1:0] ind, input logic [DATA_W-1:0] entd,
                            input logic accept);
        FIRE     = 1'b1;
        TAG      = t;
        IN_LR    = lr;
        IN_DATA  = ind;
        ENT_DATA = entd;
        if (accept) begin
            if (lr) exp_q.push_back({t, entd, ind});
            else    exp_q.push_back({t, ind, entd});
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || REQ || ACK) && n < 400) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Automatic ACK responder, reacting on the falling edge.
    always @(negedge CP) begin
        if (ack_en) begin
            if (REQ && !ack_auto) begin
                if (ack_wait >= ack_dly) begin
                    ack_auto = 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else if (!REQ && ack_auto) begin
                ack_auto = 1'b0;
            end
        end
    end

    // Monitor: on every REQ rise the presented packet must be the queue head.
    logic req_prev = 1'b0;
    always @(negedge CP) begin
        logic [ENT_W-1:0] e;
        if (REQ && !req_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pkt_unexpected: got tag %0h L %0h R %0h expected none",
                         PKT_TAG, PKT_L, PKT_R);
            end else begin
                e = exp_q.pop_front();
                if ({PKT_TAG, PKT_L, PKT_R} !== e) begin
                    errors++;
                    $display("FAIL pkt: got tag %0h L %0h R %0h expected tag %0h L %0h R %0h",
                             PKT_TAG, PKT_L, PKT_R, e[ENT_W-1 -: TAG_W],
                             e[2*DATA_W-1 -: DATA_W], e[DATA_W-1:0]);
                end
            end
        end
        req_prev = REQ;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;

        // Reset state
        #2;
        chk("rst_req", REQ, 0);
        chk("rst_full", FULL, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_pkt", {PKT_TAG, PKT_L, PKT_R} == '0, 1);
        tick();
        MR = 1'b1;
        tick();

        // Single fire, IN_LR=1, manual handshake
        fire_set(18'h0A5A5, 1'b1, 16'h1234, 16'hBEEF, 1'b1);
        tick();
        FIRE = 1'b0;
        chk("single_req_lat0", REQ, 0);
        tick();
        chk("single_req_up", REQ, 1);
        chk("single_pkt_l", PKT_L, 32'hBEEF);
        chk("single_pkt_r", PKT_R, 32'h1234);
        chk("single_pkt_tag", PKT_TAG, 32'h0A5A5);
        ack_man = 1'b1;
        tick();
        chk("single_req_down", REQ, 0);
        chk("single_pkt_hold", PKT_L, 32'hBEEF);
        ack_man = 1'b0;
        tick();
        tick();
        chk("single_idle_req", REQ, 0);
        chk("single_full", FULL, 0);
        chk("single_ovf", OVF, 0);

        // Ordering, IN_LR=0, automatic ACK
        ack_en = 1'b1;
        fire_set(18'h0A5A5, 1'b0, 16'h1234, 16'hBEEF, 1'b1);
        tick();
        FIRE = 1'b0;
        wait_drain("order_drain");
        ack_en = 1'b0;

        // Fill and overflow with ACK held low
        for (int i = 1; i <= 5; i++) begin
            fire_set(18'h00100 + 18'(i), 1'b0, DATA_W'(i), 16'h00F0, i <= 4);
            tick();
            if (i == 4) begin
                chk("fill_full4", FULL, 1);
                chk("fill_ovf4", OVF, 0);
            end
        end
        FIRE = 1'b0;
        chk("fill_ovf5", OVF, 1);
        chk("fill_full5", FULL, 1);
        chk("fill_req", REQ, 1);
        ack_man = 1'b1;
        tick();
        chk("fill_pop_req", REQ, 0);
        chk("fill_pop_full", FULL, 0);
        ack_man = 1'b0;
        ack_en  = 1'b1;
        wait_drain("fill_drain");
        repeat (4) tick();
        chk("fill_no_extra", REQ, 0);
        chk("fill_ovf_sticky", OVF, 1);

        // Stream 10 packets with ACK one cycle late; fire whenever not full
        do_reset();
        ack_dly = 1;
        sent = 0;
        while (sent < 10) begin
            if (!FULL) begin
                fire_set(18'h20000 + 18'(sent), sent[0], DATA_W'(16'h0111 * (sent + 1)),
                         DATA_W'(16'hA000 + sent), 1'b1);
                sent++;
            end else begin
                FIRE = 1'b0;
            end
            tick();
        end
        FIRE = 1'b0;
        wait_drain("stream_drain");
        chk("stream_ovf", OVF, 0);
        chk("stream_full", FULL, 0);
        ack_en  = 1'b0;
        ack_dly = 0;

        // ACK stuck high while two packets wait
        ack_man = 1'b1;
        fire_set(18'h3AAAA, 1'b0, 16'h5555, 16'h6666, 1'b1);
        tick();
        fire_set(18'h3BBBB, 1'b1, 16'h7777, 16'h8888, 1'b1);
        tick();
        FIRE = 1'b0;
        repeat (3) tick();
        chk("stuck_req_low", REQ, 0);
        ack_man = 1'b0;
        tick();
        chk("stuck_req_up", REQ, 1);
        chk("stuck_head_l", PKT_L, 32'h5555);
        ack_en = 1'b1;
        wait_drain("stuck_drain");
        ack_en = 1'b0;

        // Reset mid-operation: REQ=1, count=3, OVF=1
        for (int i = 1; i <= 5; i++) begin
            fire_set(18'h01000 + 18'(i), 1'b1, DATA_W'(i), 16'h0C00, i <= 4);
            tick();
        end
        FIRE = 1'b0;
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        tick();
        tick();
        chk("mid_req_pre", REQ, 1);
        chk("mid_ovf_pre", OVF, 1);
        chk("mid_full_pre", FULL, 0);
        MR = 1'b0;
        #1;
        chk("mid_rst_req", REQ, 0);
        chk("mid_rst_ovf", OVF, 0);
        chk("mid_rst_full", FULL, 0);
        chk("mid_rst_pkt", {PKT_TAG, PKT_L, PKT_R} == '0, 1);
        exp_q.delete();
        #1;
        MR = 1'b1;
        repeat (5) tick();
        chk("mid_after_req", REQ, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
